// File: rtl/arb2_rr.sv
// arb2_rr: two-source round-robin valid/ready arbiter feeding a single registered output slot.
module arb2_rr #(
    parameter int DWIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid0,
    input  logic [DWIDTH-1:0] i_data0,
    output logic              o_ready0,
    input  logic              i_valid1,
    input  logic [DWIDTH-1:0] i_data1,
    output logic              o_ready1,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_sel,
    input  logic              i_ready
);
    logic              r_valid;
    logic [DWIDTH-1:0] r_data;
    logic              r_sel;
    logic              r_prio;
    logic              w_load;
    logic              w_any;
    logic              w_win;

    assign w_load   = ~r_valid | i_ready;
    assign w_any    = i_valid0 | i_valid1;
    // Priority only matters on a tie; otherwise the lone valid source wins.
    assign w_win    = (i_valid0 & i_valid1) ? r_prio : i_valid1;
    assign o_ready0 = w_load & i_valid0 & ~w_win;
    assign o_ready1 = w_load & i_valid1 & w_win;
    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_sel    = r_sel;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= 1'b0;
            r_prio  <= 1'b0;
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= w_win ? i_data1 : i_data0;
                r_sel  <= w_win;
                r_prio <= ~w_win;
            end
        end
    end
endmodule

// File: tb/tb_arb2_rr.sv
// tb_arb2_rr: directed and random checks of arb2_rr against a slot/queue reference model.
module tb_arb2_rr;
    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_valid0 = 1'b0, i_valid1 = 1'b0, i_ready = 1'b0;
    logic [7:0] i_data0 = '0, i_data1 = '0;
    logic       o_ready0, o_ready1, o_valid, o_sel;
    logic [7:0] o_data;
    int         total = 0, bad = 0;

    arb2_rr #(.DWIDTH(8)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_valid0(i_valid0), .i_data0(i_data0), .o_ready0(o_ready0),
        .i_valid1(i_valid1), .i_data1(i_data1), .o_ready1(o_ready1),
        .o_valid(o_valid), .o_data(o_data), .o_sel(o_sel), .i_ready(i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: one slot, a preferred-source index, and per-source queues of accepted beats.
    bit       m_v = 0, m_s = 0;
    int       m_p = 0;
    int       m_d = 0;
    int       q[2][$];
    always @(negedge i_clk) begin
        bit v[2];
        int d[2];
        int win;
        bit load;
        v[0] = i_valid0; v[1] = i_valid1; d[0] = i_data0; d[1] = i_data1;
        if (!i_rstn) begin
            chk("rst_valid", o_valid, 0);
            chk("rst_data", o_data, 0);
            chk("rst_sel", o_sel, 0);
            m_v = 0; m_s = 0; m_p = 0; m_d = 0;
            q[0].delete(); q[1].delete();
        end else begin
            chk("m_valid", o_valid, m_v);
            if (m_v) begin
                chk("m_data", o_data, m_d);
                chk("m_sel", o_sel, m_s);
            end
            load = !m_v || i_ready;
            win = -1;
            if (load) win = (v[0] && v[1]) ? m_p : v[0] ? 0 : v[1] ? 1 : -1;
            chk("m_ready0", o_ready0, win == 0);
            chk("m_ready1", o_ready1, win == 1);
            chk("excl_ready", o_ready0 & o_ready1, 0);
            if (m_v && i_ready) begin
                if (q[m_s].size() == 0) chk("sb_empty", 1, 0);
                else chk("sb_order", o_data, q[m_s].pop_front());
            end
            if (load) begin
                if (win >= 0) begin
                    q[win].push_back(d[win]);
                    m_v = 1; m_s = win[0]; m_d = d[win]; m_p = 1 - win;
                end else m_v = 0;
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        bit r0, r1;
        int a, b;
        repeat (2) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        chk("lit_rst_valid", o_valid, 0);
        chk("lit_rst_sel", o_sel, 0);
        // reset mid-beat
        i_valid0 = 1; i_data0 = 8'h5A;
        tick();
        chk("lit_load5a", o_data, 8'h5A);
        i_valid0 = 0;
        i_rstn = 0;
        #1;
        chk("lit_async_valid", o_valid, 0);
        chk("lit_async_data", o_data, 0);
        chk("lit_async_sel", o_sel, 0);
        tick();
        i_rstn = 1;
        i_valid0 = 1; i_valid1 = 1; i_data0 = 8'h11; i_data1 = 8'h22; i_ready = 1;
        #1;
        chk("lit_post_rst_r0", o_ready0, 1);
        chk("lit_post_rst_r1", o_ready1, 0);
        tick();
        chk("lit_post_rst_data", o_data, 8'h11);
        // single source stream on src1
        i_valid0 = 0;
        for (int i = 1; i <= 4; i++) begin
            i_data1 = 8'(i);
            #1;
            chk("lit_s1_r1", o_ready1, 1);
            chk("lit_s1_r0", o_ready0, 0);
            tick();
            chk("lit_s1_data", o_data, i);
            chk("lit_s1_sel", o_sel, 1);
            chk("lit_s1_valid", o_valid, 1);
        end
        // contention, prio=0 at start
        a = 0; b = 0;
        i_valid0 = 1; i_valid1 = 1;
        for (int k = 0; k < 6; k++) begin
            i_data0 = 8'(8'hA0 + a); i_data1 = 8'(8'hB0 + b);
            tick();
            chk("lit_ct_sel", o_sel, k % 2);
            chk("lit_ct_data", o_data, (k % 2 == 0) ? 8'hA0 + k / 2 : 8'hB0 + k / 2);
            chk("lit_ct_valid", o_valid, 1);
            if (k % 2 == 0) a++; else b++;
        end
        // backpressure with held 0x33 from src1
        i_valid0 = 0; i_data1 = 8'h33;
        tick();
        i_ready = 0; i_valid0 = 1; i_data0 = 8'h44; i_data1 = 8'h55;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lit_bp_r0", o_ready0, 0);
            chk("lit_bp_r1", o_ready1, 0);
            tick();
            chk("lit_bp_data", o_data, 8'h33);
            chk("lit_bp_sel", o_sel, 1);
        end
        i_ready = 1;
        #1;
        chk("lit_bp_rel_r0", o_ready0, 1);
        tick();
        chk("lit_bp_rel_data", o_data, 8'h44);
        chk("lit_bp_rel_sel", o_sel, 0);
        // drain, prio stays 1
        i_valid0 = 0; i_valid1 = 0;
        tick();
        chk("lit_drain_valid", o_valid, 0);
        i_valid0 = 1; i_valid1 = 1; i_data0 = 8'h77; i_data1 = 8'h66;
        #1;
        chk("lit_drain_r1", o_ready1, 1);
        chk("lit_drain_r0", o_ready0, 0);
        tick();
        chk("lit_drain_data", o_data, 8'h66);
        chk("lit_drain_sel", o_sel, 1);
        i_valid1 = 0;
        // random mix; an ungranted valid beat stays stable
        for (int k = 0; k < 200; k++) begin
            #1;
            r0 = o_ready0; r1 = o_ready1;
            tick();
            if (!(i_valid0 && !r0)) begin
                i_valid0 = 1'($urandom_range(0, 1));
                i_data0 = 8'($urandom);
            end
            if (!(i_valid1 && !r1)) begin
                i_valid1 = 1'($urandom_range(0, 1));
                i_data1 = 8'($urandom);
            end
            i_ready = 1'($urandom_range(0, 3) != 0);
        end
        i_valid0 = 0; i_valid1 = 0; i_ready = 1;
        repeat (3) tick();
        chk("end_q0_empty", q[0].size(), 0);
        chk("end_q1_empty", q[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
